// File: rtl/dekatron_step_sequencer.sv
// Two-phase guide-pulse generator for dekatron counting tubes.
// Moves the glow by a commanded number of cathodes in either direction.
module dekatron_step_sequencer #(
    parameter int PHASE_LEN = 3,
    parameter int GAP_LEN   = 1,
    parameter int STEP_W    = 4
) (
    input  logic              hsClk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic              Dir,
    input  logic [STEP_W-1:0] Steps,
    input  logic              Stop,
    output logic [1:0]        Pulses,
    output logic              Busy,
    output logic              Done,
    output logic              StepStrobe,
    output logic [STEP_W-1:0] StepsLeft
);

    localparam int PH_MAX = (PHASE_LEN > 1) ? PHASE_LEN : 1;
    localparam int MAXLEN = (PH_MAX > GAP_LEN) ? PH_MAX : GAP_LEN;
    localparam int CW     = $clog2(MAXLEN + 1);
    localparam logic [CW-1:0] PH_LOAD  = CW'(PH_MAX - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

    typedef enum logic [1:0] {IDLE, PH1, PH2, GAP} state_t;

    state_t            state;
    logic [CW-1:0]     phaseCnt;
    logic              dirLatch;
    logic              stopFlag;
    logic [STEP_W-1:0] leftAfterStep;
    logic              haltFromGap;
    logic              haltFromPh2;

    // A Stop seen in the cycle that closes a step still ends the command there.
    assign leftAfterStep = StepsLeft - STEP_W'(1);
    assign haltFromGap   = (StepsLeft == '0) || stopFlag || Stop;
    assign haltFromPh2   = (leftAfterStep == '0) || stopFlag || Stop;

    always_ff @(posedge hsClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            phaseCnt   <= '0;
            dirLatch   <= 1'b0;
            stopFlag   <= 1'b0;
            Pulses     <= 2'b00;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            StepStrobe <= 1'b0;
            StepsLeft  <= '0;
        end else begin
            Done       <= 1'b0;
            StepStrobe <= 1'b0;
            if (state != IDLE && Stop) begin
                stopFlag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (Steps != '0) begin
                            dirLatch  <= Dir;
                            StepsLeft <= Steps;
                            stopFlag  <= 1'b0;
                            state     <= PH1;
                            phaseCnt  <= PH_LOAD;
                            Pulses    <= Dir ? 2'b10 : 2'b01;
                            Busy      <= 1'b1;
                        end else begin
                            Done <= 1'b1;
                        end
                    end
                end
                PH1: begin
                    if (phaseCnt == '0) begin
                        state      <= PH2;
                        phaseCnt   <= PH_LOAD;
                        Pulses     <= dirLatch ? 2'b01 : 2'b10;
                        StepStrobe <= (PH_MAX == 1);
                    end else begin
                        phaseCnt <= phaseCnt - CW'(1);
                    end
                end
                PH2: begin
                    if (phaseCnt == '0) begin
                        StepsLeft <= leftAfterStep;
                        if (GAP_LEN > 0) begin
                            state    <= GAP;
                            phaseCnt <= GAP_LOAD;
                            Pulses   <= 2'b00;
                        end else if (haltFromPh2) begin
                            state  <= IDLE;
                            Pulses <= 2'b00;
                            Busy   <= 1'b0;
                            Done   <= 1'b1;
                        end else begin
                            state    <= PH1;
                            phaseCnt <= PH_LOAD;
                            Pulses   <= dirLatch ? 2'b10 : 2'b01;
                        end
                    end else begin
                        StepStrobe <= (phaseCnt == CW'(1));
                        phaseCnt   <= phaseCnt - CW'(1);
                    end
                end
                GAP: begin
                    if (phaseCnt == '0) begin
                        if (haltFromGap) begin
                            state  <= IDLE;
                            Pulses <= 2'b00;
                            Busy   <= 1'b0;
                            Done   <= 1'b1;
                        end else begin
                            state    <= PH1;
                            phaseCnt <= PH_LOAD;
                            Pulses   <= dirLatch ? 2'b10 : 2'b01;
                        end
                    end else begin
                        phaseCnt <= phaseCnt - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    Pulses <= 2'b00;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
